// File: rtl/qspi_pkg.sv
// Shared types and helpers for the QSPI TX drain block.
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } qspi_tx_state_e;

  localparam int QSPI_IO_W = 4;

  function automatic int nib_cnt(input int data_width);
    return data_width / QSPI_IO_W;
  endfunction

endpackage

// File: rtl/qspi_tx_drain_if.sv
// FIFO read port plus QSPI pad signals; master is the drain, slave is the FIFO/pad side.
interface qspi_tx_drain_if
  import qspi_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) ();

  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  empty;
  logic                  qspi_sclk;
  logic                  qspi_cs_n;
  logic [QSPI_IO_W-1:0]  qspi_io;
  logic                  qspi_oe;

  modport master (
    output ren,
    input  rdata,
    input  empty,
    output qspi_sclk,
    output qspi_cs_n,
    output qspi_io,
    output qspi_oe
  );

  modport slave (
    input  ren,
    output rdata,
    output empty,
    input  qspi_sclk,
    input  qspi_cs_n,
    input  qspi_io,
    input  qspi_oe
  );

endinterface

// File: rtl/qspi_sclk_gen.sv
// SCLK half-period timer: toggles SCLK every CLK_DIV enabled cycles, idles low.
// rise/fall strobe in the cycle before SCLK changes; clr or !en returns it to idle low.
module qspi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV) + 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;

  always_ff @(posedge clk) begin
    if (clr || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/qspi_tx_drain.sv
// Pops len words from the TX FIFO and shifts them out MSB nibble first under one CS frame.
// First ren one cycle after start, io at 2+DELAY; an empty FIFO stalls the frame with SCLK low.
module qspi_tx_drain
  import qspi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DELAY      = 1,
  parameter int CLK_DIV    = 2,
  parameter int LEN_W      = 8
) (
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  qspi_tx_drain_if.master  bus
);

  localparam int NIB = nib_cnt(DATA_WIDTH);
  localparam int NCW = $clog2(NIB) + 1;

  if (DATA_WIDTH % QSPI_IO_W != 0) begin : g_bad_width
    $error("qspi_tx_drain: DATA_WIDTH must be a multiple of 4");
  end
  if (DELAY != 0 && DELAY != 1) begin : g_bad_delay
    $error("qspi_tx_drain: DELAY must be 0 or 1");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("qspi_tx_drain: CLK_DIV must be at least 1");
  end

  qspi_tx_state_e        state_q, state_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [NCW-1:0]        nib_q, nib_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;
  logic                  cs_n_q, cs_n_d;
  logic                  oe_q, oe_d;
  logic                  pop;
  logic                  sclk, sclk_rise, sclk_fall;

  qspi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk  (r_clk),
    .clr  (r_rst),
    .en   (state_q == SHIFT),
    .sclk (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    shreg_d    = shreg_q;
    nib_d      = nib_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    cs_n_d     = cs_n_q;
    oe_d       = oe_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            rem_d      = len;
            underrun_d = 1'b0;
            busy_d     = 1'b1;
            cs_n_d     = 1'b0;
            oe_d       = 1'b1;
            state_d    = FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      FETCH: begin
        if (!bus.empty) begin
          pop   = 1'b1;
          nib_d = '0;
          if (DELAY == 0) begin
            shreg_d = bus.rdata;
            state_d = SHIFT;
          end else begin
            state_d = WAIT;
          end
        end else begin
          underrun_d = 1'b1;
        end
      end

      WAIT: begin
        shreg_d = bus.rdata;
        state_d = SHIFT;
      end

      SHIFT: begin
        // nibbles are counted as the slave captures them, so the word ends on the fall after the last rise
        if (sclk_rise) begin
          nib_d = nib_q + NCW'(1);
        end
        if (sclk_fall) begin
          if (nib_q == NCW'(NIB)) begin
            nib_d = '0;
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              busy_d  = 1'b0;
              cs_n_d  = 1'b1;
              oe_d    = 1'b0;
              done_d  = 1'b1;
              shreg_d = '0;
              state_d = DONE;
            end else begin
              state_d = FETCH;
            end
          end else begin
            shreg_d = shreg_q << QSPI_IO_W;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      shreg_q    <= '0;
      nib_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      cs_n_q     <= 1'b1;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      shreg_q    <= shreg_d;
      nib_q      <= nib_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      cs_n_q     <= cs_n_d;
      oe_q       <= oe_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign underrun      = underrun_q;
  assign bus.ren       = pop && !r_rst;
  assign bus.qspi_sclk = sclk;
  assign bus.qspi_cs_n = cs_n_q;
  assign bus.qspi_io   = shreg_q[DATA_WIDTH-1 -: QSPI_IO_W];
  assign bus.qspi_oe   = oe_q;

endmodule

// File: tb/tb_qspi_tx_drain.sv
// Directed bench: DUT1 (DELAY=1, CLK_DIV=2) for frame/underrun/reset cases, DUT0 (DELAY=0, CLK_DIV=1) for the long frame.
module tb_qspi_tx_drain;

  logic       r_clk = 1'b0;
  logic       r_rst;
  logic       start1, start0;
  logic [7:0] len1, len0;
  logic       busy1, done1, underrun1;
  logic       busy0, done0, underrun0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 r_clk = ~r_clk;
  always @(posedge r_clk) cyc <= cyc + 1;

  qspi_tx_drain_if #(.DATA_WIDTH(8)) bus1 ();
  qspi_tx_drain_if #(.DATA_WIDTH(8)) bus0 ();

  qspi_tx_drain #(.DATA_WIDTH(8), .DELAY(1), .CLK_DIV(2), .LEN_W(8)) u_dut1 (
    .r_clk    (r_clk),
    .r_rst    (r_rst),
    .start    (start1),
    .len      (len1),
    .busy     (busy1),
    .done     (done1),
    .underrun (underrun1),
    .bus      (bus1)
  );

  qspi_tx_drain #(.DATA_WIDTH(8), .DELAY(0), .CLK_DIV(1), .LEN_W(8)) u_dut0 (
    .r_clk    (r_clk),
    .r_rst    (r_rst),
    .start    (start0),
    .len      (len0),
    .busy     (busy0),
    .done     (done0),
    .underrun (underrun0),
    .bus      (bus0)
  );

  // FIFO models: registered read for DUT1, show-ahead read for DUT0
  logic [7:0] mem1 [0:511];
  logic [7:0] mem0 [0:511];
  int wp1 = 0, rp1 = 0, wp0 = 0, rp0 = 0;

  assign bus1.empty = (wp1 == rp1);
  assign bus0.empty = (wp0 == rp0);
  assign bus0.rdata = mem0[rp0[8:0]];

  always @(posedge r_clk) begin
    if (bus1.ren && (wp1 != rp1)) begin
      bus1.rdata <= mem1[rp1[8:0]];
      rp1        <= rp1 + 1;
    end
    if (bus0.ren && (wp0 != rp0)) rp0 <= rp0 + 1;
  end

  // Monitors sample mid-cycle
  int pops1 = 0, badpop1 = 0, rises1 = 0, dones1 = 0, done_cyc1 = 0;
  int busycyc1 = 0, csbad1 = 0, cslow1 = 0;
  int pops0 = 0, badpop0 = 0, rises0 = 0, dones0 = 0, done_cyc0 = 0;
  logic prev_sclk1 = 1'b0, prev_sclk0 = 1'b0;
  logic [3:0] nib1 [0:2047];
  logic [3:0] nib0 [0:2047];
  int rcyc1 [0:2047];

  always @(negedge r_clk) begin
    if (bus1.ren && !bus1.empty) pops1 <= pops1 + 1;
    if (bus1.ren && bus1.empty) badpop1 <= badpop1 + 1;
    if (bus1.qspi_sclk && !prev_sclk1) begin
      nib1[rises1[10:0]]  <= bus1.qspi_io;
      rcyc1[rises1[10:0]] <= cyc;
      rises1              <= rises1 + 1;
    end
    prev_sclk1 <= bus1.qspi_sclk;
    if (done1) begin
      dones1    <= dones1 + 1;
      done_cyc1 <= cyc;
    end
    if (busy1) busycyc1 <= busycyc1 + 1;
    if (busy1 && bus1.qspi_cs_n) csbad1 <= csbad1 + 1;
    if (!bus1.qspi_cs_n) cslow1 <= cslow1 + 1;

    if (bus0.ren && !bus0.empty) pops0 <= pops0 + 1;
    if (bus0.ren && bus0.empty) badpop0 <= badpop0 + 1;
    if (bus0.qspi_sclk && !prev_sclk0) begin
      nib0[rises0[10:0]] <= bus0.qspi_io;
      rises0             <= rises0 + 1;
    end
    prev_sclk0 <= bus0.qspi_sclk;
    if (done0) begin
      dones0    <= dones0 + 1;
      done_cyc0 <= cyc;
    end
  end

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] d);
    mem1[wp1[8:0]] = d;
    wp1 = wp1 + 1;
  endtask

  task automatic wait_done1(input int maxc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      tick();
      if (done1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [10:0] got1, got0;
    r_rst = 1'b1; start1 = 1'b0; start0 = 1'b0; len1 = '0; len0 = '0;
    repeat (3) tick();
    got1 = {busy1, done1, underrun1, bus1.ren, bus1.qspi_sclk, bus1.qspi_cs_n, bus1.qspi_io, bus1.qspi_oe};
    got0 = {busy0, done0, underrun0, bus0.ren, bus0.qspi_sclk, bus0.qspi_cs_n, bus0.qspi_io, bus0.qspi_oe};
    n_cmp++;
    if (got1 !== 11'b000_0_0_1_0000_0) begin
      n_err++; $display("FAIL reset_dut1 got=%b exp=%b", got1, 11'b000_0_0_1_0000_0);
    end
    n_cmp++;
    if (got0 !== 11'b000_0_0_1_0000_0) begin
      n_err++; $display("FAIL reset_dut0 got=%b exp=%b", got0, 11'b000_0_0_1_0000_0);
    end
    r_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    int c0, rb, pb, db;
    bit seen;
    logic [15:0] got;
    rb = rises1; pb = pops1; db = dones1;
    push1(8'hA5); push1(8'h3C);
    start1 = 1'b1; len1 = 8'd2; c0 = cyc;
    tick();
    start1 = 1'b0;
    n_cmp++;
    if ({bus1.qspi_cs_n, bus1.ren, busy1, bus1.qspi_oe} !== 4'b0111) begin
      n_err++; $display("FAIL basic_cycle1 got=%b exp=0111", {bus1.qspi_cs_n, bus1.ren, busy1, bus1.qspi_oe});
    end
    tick(); tick();
    n_cmp++;
    if ({bus1.qspi_io, bus1.qspi_sclk} !== 5'b1010_0) begin
      n_err++; $display("FAIL basic_io_cycle3 got=%b exp=10100", {bus1.qspi_io, bus1.qspi_sclk});
    end
    wait_done1(100, seen);
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL basic_done_timeout got=0 exp=1"); end
    tick();
    got = {nib1[11'(rb)], nib1[11'(rb + 1)], nib1[11'(rb + 2)], nib1[11'(rb + 3)]};
    n_cmp++;
    if (got !== 16'hA53C) begin n_err++; $display("FAIL basic_nibbles got=%h exp=a53c", got); end
    n_cmp++;
    if (rises1 - rb !== 4) begin n_err++; $display("FAIL basic_rises got=%0d exp=4", rises1 - rb); end
    n_cmp++;
    if (pops1 - pb !== 2) begin n_err++; $display("FAIL basic_pops got=%0d exp=2", pops1 - pb); end
    n_cmp++;
    if (dones1 - db !== 1) begin n_err++; $display("FAIL basic_dones got=%0d exp=1", dones1 - db); end
    n_cmp++;
    if (rcyc1[11'(rb)] - c0 !== 5) begin
      n_err++; $display("FAIL basic_first_rise got=%0d exp=5", rcyc1[11'(rb)] - c0);
    end
    n_cmp++;
    if (done_cyc1 - c0 !== 21) begin n_err++; $display("FAIL basic_done_cycle got=%0d exp=21", done_cyc1 - c0); end
    n_cmp++;
    if (csbad1 !== 0) begin n_err++; $display("FAIL basic_cs_high_while_busy got=%0d exp=0", csbad1); end
  endtask

  task automatic test_len_zero();
    int rb, pb, bp, db, bc, cl;
    rb = rises1; pb = pops1; bp = badpop1; db = dones1; bc = busycyc1; cl = cslow1;
    start1 = 1'b1; len1 = 8'd0;
    tick();
    start1 = 1'b0;
    n_cmp++;
    if ({done1, busy1, bus1.qspi_cs_n} !== 3'b101) begin
      n_err++; $display("FAIL len0_cycle1 got=%b exp=101", {done1, busy1, bus1.qspi_cs_n});
    end
    repeat (6) tick();
    n_cmp++;
    if ({rises1 - rb, pops1 - pb, badpop1 - bp, busycyc1 - bc, cslow1 - cl} !== 160'd0) begin
      n_err++; $display("FAIL len0_activity got=rises%0d pops%0d bad%0d busy%0d cslow%0d exp=all0",
                        rises1 - rb, pops1 - pb, badpop1 - bp, busycyc1 - bc, cslow1 - cl);
    end
    n_cmp++;
    if (dones1 - db !== 1) begin n_err++; $display("FAIL len0_dones got=%0d exp=1", dones1 - db); end
  endtask

  task automatic test_underrun();
    int rb, pb;
    bit seen;
    logic [23:0] got;
    rb = rises1; pb = pops1;
    push1(8'h96);
    start1 = 1'b1; len1 = 8'd3;
    tick();
    start1 = 1'b0;
    repeat (19) tick();
    n_cmp++;
    if ({underrun1, bus1.qspi_sclk, bus1.qspi_cs_n, busy1, bus1.ren} !== 5'b10010) begin
      n_err++; $display("FAIL underrun_stall got=%b exp=10010",
                        {underrun1, bus1.qspi_sclk, bus1.qspi_cs_n, busy1, bus1.ren});
    end
    n_cmp++;
    if (pops1 - pb !== 1) begin n_err++; $display("FAIL underrun_pops_stall got=%0d exp=1", pops1 - pb); end
    push1(8'h1E); push1(8'h7B);
    wait_done1(100, seen);
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL underrun_done_timeout got=0 exp=1"); end
    tick();
    got = {nib1[11'(rb)], nib1[11'(rb + 1)], nib1[11'(rb + 2)],
           nib1[11'(rb + 3)], nib1[11'(rb + 4)], nib1[11'(rb + 5)]};
    n_cmp++;
    if (got !== 24'h961E7B) begin n_err++; $display("FAIL underrun_nibbles got=%h exp=961e7b", got); end
    n_cmp++;
    if ({underrun1, badpop1} !== {1'b1, 32'd0}) begin
      n_err++; $display("FAIL underrun_sticky got=und%0d bad%0d exp=und1 bad0", underrun1, badpop1);
    end
    // start right in the cycle after done; underrun must clear
    rb = rises1;
    push1(8'h42);
    start1 = 1'b1; len1 = 8'd1;
    tick();
    start1 = 1'b0;
    n_cmp++;
    if ({busy1, underrun1} !== 2'b10) begin
      n_err++; $display("FAIL underrun_clear got=%b exp=10", {busy1, underrun1});
    end
    wait_done1(100, seen);
    tick();
    n_cmp++;
    if ({nib1[11'(rb)], nib1[11'(rb + 1)]} !== 8'h42 || !seen) begin
      n_err++; $display("FAIL underrun_next_frame got=%h done=%0d exp=42 done=1",
                        {nib1[11'(rb)], nib1[11'(rb + 1)]}, seen);
    end
  endtask

  task automatic test_start_while_busy();
    int rb, pb, db;
    bit seen;
    logic [15:0] got;
    rb = rises1; pb = pops1; db = dones1;
    push1(8'h11); push1(8'h22); push1(8'h33);
    start1 = 1'b1; len1 = 8'd2;
    tick();
    start1 = 1'b0;
    repeat (3) tick();
    start1 = 1'b1; len1 = 8'd5;
    tick();
    start1 = 1'b0;
    wait_done1(100, seen);
    tick();
    got = {nib1[11'(rb)], nib1[11'(rb + 1)], nib1[11'(rb + 2)], nib1[11'(rb + 3)]};
    n_cmp++;
    if (got !== 16'h1122 || !seen) begin
      n_err++; $display("FAIL busy_start_nibbles got=%h done=%0d exp=1122 done=1", got, seen);
    end
    repeat (10) tick();
    n_cmp++;
    if (pops1 - pb !== 2) begin n_err++; $display("FAIL busy_start_pops got=%0d exp=2", pops1 - pb); end
    n_cmp++;
    if (dones1 - db !== 1) begin n_err++; $display("FAIL busy_start_dones got=%0d exp=1", dones1 - db); end
    n_cmp++;
    if ({busy1, bus1.qspi_cs_n} !== 2'b01 || wp1 - rp1 !== 1) begin
      n_err++; $display("FAIL busy_start_idle got=busy%0d cs_n%0d left%0d exp=busy0 cs_n1 left1",
                        busy1, bus1.qspi_cs_n, wp1 - rp1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rb, pb;
    bit seen;
    pb = pops1;
    push1(8'h5A); push1(8'h6B);
    start1 = 1'b1; len1 = 8'd3;
    tick();
    start1 = 1'b0;
    repeat (14) tick();
    n_cmp++;
    if (pops1 - pb !== 2 || busy1 !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_pre got=pops%0d busy%0d exp=pops2 busy1", pops1 - pb, busy1);
    end
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    n_cmp++;
    if ({bus1.qspi_cs_n, bus1.qspi_oe, bus1.qspi_sclk, busy1} !== 4'b1000) begin
      n_err++; $display("FAIL rst_mid_outputs got=%b exp=1000",
                        {bus1.qspi_cs_n, bus1.qspi_oe, bus1.qspi_sclk, busy1});
    end
    rb = rises1; pb = pops1;
    start1 = 1'b1; len1 = 8'd1;
    tick();
    start1 = 1'b0;
    wait_done1(100, seen);
    tick();
    n_cmp++;
    if ({nib1[11'(rb)], nib1[11'(rb + 1)]} !== 8'h6B || pops1 - pb !== 1 || !seen) begin
      n_err++; $display("FAIL rst_mid_next_word got=%h pops%0d done%0d exp=6b pops1 done1",
                        {nib1[11'(rb)], nib1[11'(rb + 1)]}, pops1 - pb, seen);
    end
  endtask

  task automatic test_long_frame();
    int c0, rb, bad;
    bit seen;
    logic [7:0] e;
    rb = rises0;
    for (int k = 0; k < 255; k++) begin
      mem0[wp0[8:0]] = 8'(k * 7 + 3);
      wp0 = wp0 + 1;
    end
    start0 = 1'b1; len0 = 8'd255; c0 = cyc;
    tick();
    start0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      if (done0) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL long_done_timeout got=0 exp=1"); end
    tick();
    n_cmp++;
    if (pops0 !== 255 || badpop0 !== 0) begin
      n_err++; $display("FAIL long_pops got=%0d bad=%0d exp=255 bad=0", pops0, badpop0);
    end
    n_cmp++;
    if (rises0 - rb !== 510) begin n_err++; $display("FAIL long_rises got=%0d exp=510", rises0 - rb); end
    n_cmp++;
    if (done_cyc0 - c0 !== 1276) begin
      n_err++; $display("FAIL long_done_cycle got=%0d exp=1276", done_cyc0 - c0);
    end
    n_cmp++;
    if (dones0 !== 1 || busy0 !== 1'b0 || underrun0 !== 1'b0) begin
      n_err++; $display("FAIL long_status got=dones%0d busy%0d und%0d exp=1 0 0", dones0, busy0, underrun0);
    end
    bad = 0;
    for (int k = 0; k < 255; k++) begin
      e = 8'(k * 7 + 3);
      if (nib0[11'(rb + 2 * k)] !== e[7:4] || nib0[11'(rb + 2 * k + 1)] !== e[3:0]) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL long_data got=%0d bad words exp=0", bad); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=no finish exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_len_zero();
    test_underrun();
    test_start_while_busy();
    test_reset_mid_frame();
    test_long_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
